// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch stage and its helpers.
package fetch_pkg;

   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_INSTR_W  = 32;
   localparam int DEF_PC_AHEAD = 2;
   localparam int OFFSET_W     = 24;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: pc + PC_AHEAD + offset, wrapping modulo 2**ADDR_W.
module branch_target_calc
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int PC_AHEAD = DEF_PC_AHEAD
) (
   input  logic [ADDR_W-1:0]   pc,
   input  logic [OFFSET_W-1:0] offset,
   output logic [ADDR_W-1:0]   target
);

   // Offset bits above the PC width cannot affect a wrapped word address.
   logic unused_offset_hi;
   assign unused_offset_hi = ^offset[OFFSET_W-1:ADDR_W];

   assign target = pc + ADDR_W'(PC_AHEAD) + offset[ADDR_W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a 1-cycle-latency ROM and
// hands one instruction per cycle to decode, with stall and branch redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int INSTR_W  = DEF_INSTR_W,
   parameter int PC_AHEAD = DEF_PC_AHEAD
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_i,
   input  logic                branch_taken_i,
   input  logic [OFFSET_W-1:0] branch_offset_i,
   output logic [ADDR_W-1:0]   rom_addr_o,
   input  logic [INSTR_W-1:0]  rom_data_i,
   output logic [INSTR_W-1:0]  instr_o,
   output logic [ADDR_W-1:0]   pc_o,
   output logic                valid_o
);

   fetch_state_e       state_reg;
   logic [ADDR_W-1:0]  fpc_reg;
   logic [ADDR_W-1:0]  pc_reg;
   logic [INSTR_W-1:0] instr_reg;
   logic               valid_reg;

   logic [ADDR_W-1:0]  target;
   logic [ADDR_W-1:0]  fpc_inc;
   logic               load_en;
   logic               redirect;

   branch_target_calc #(
      .ADDR_W   (ADDR_W),
      .PC_AHEAD (PC_AHEAD)
   ) u_target (
      .pc     (pc_reg),
      .offset (branch_offset_i),
      .target (target)
   );

   always_comb begin
      fpc_inc  = fpc_reg + ADDR_W'(1);
      load_en  = (state_reg == RUN) && (!valid_reg || !stall_i);
      redirect = valid_reg && branch_taken_i;
      // While stalled the current fetch address is re-read so rom_data_i stays put.
      if (rst || state_reg == BOOT) begin
         rom_addr_o = '0;
      end else if (redirect) begin
         rom_addr_o = target;
      end else if (load_en) begin
         rom_addr_o = fpc_inc;
      end else begin
         rom_addr_o = fpc_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= BOOT;
         fpc_reg   <= '0;
         pc_reg    <= '0;
         instr_reg <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= RUN;
         if (redirect) begin
            // Data already on rom_data_i is the wrong path; drop it as a bubble.
            fpc_reg   <= target;
            valid_reg <= 1'b0;
         end else if (load_en) begin
            instr_reg <= rom_data_i;
            pc_reg    <= fpc_reg;
            valid_reg <= 1'b1;
            fpc_reg   <= fpc_inc;
         end
      end
   end

   assign instr_o = instr_reg;
   assign pc_o    = pc_reg;
   assign valid_o = valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit against a latency-rule model of the
// delivered instruction stream, with a behavioural 1-cycle ROM.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int AW = 8;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall_i = 1'b0;
   logic          branch_taken_i = 1'b0;
   logic [23:0]   branch_offset_i = '0;
   logic [AW-1:0] rom_addr_o;
   logic [IW-1:0] rom_data_i;
   logic [IW-1:0] instr_o;
   logic [AW-1:0] pc_o;
   logic          valid_o;

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .PC_AHEAD (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_offset_i (branch_offset_i),
      .rom_addr_o      (rom_addr_o),
      .rom_data_i      (rom_data_i),
      .instr_o         (instr_o),
      .pc_o            (pc_o),
      .valid_o         (valid_o)
   );

   function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
      return 32'hA000_0000 + {24'd0, a};
   endfunction

   always @(posedge clk) rom_data_i <= rom_word(rom_addr_o);

   typedef struct {
      logic          valid;
      logic          zero;
      logic [AW-1:0] pc;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int failures = 0;
   int timeouts = 0;
   bit done = 1'b0;

   // Stream model: pc of the instruction on display, next pc in program order,
   // and how many edges remain before the next instruction appears.
   logic          m_valid = 1'b0;
   logic          m_zero = 1'b1;
   logic [AW-1:0] m_pc = '0;
   logic [AW-1:0] m_nxt = '0;
   int            m_wait = 2;

   task automatic step(input logic r, input logic s, input logic b, input logic [23:0] off);
      exp_t e;
      rst = r;
      stall_i = s;
      branch_taken_i = b;
      branch_offset_i = off;
      e.valid = m_valid;
      e.zero  = m_zero;
      e.pc    = m_pc;
      if (r || m_wait == 2)    e.addr = '0;
      else if (m_valid && b)   e.addr = m_pc + 8'd2 + off[7:0];
      else if (m_valid && s)   e.addr = m_nxt;
      else                     e.addr = m_nxt + 8'd1;
      q.push_back(e);
      if (r) begin
         m_valid = 1'b0; m_zero = 1'b1; m_pc = '0; m_nxt = '0; m_wait = 2;
      end else if (m_valid && b) begin
         m_valid = 1'b0; m_nxt = m_pc + 8'd2 + off[7:0]; m_wait = 1;
      end else if (m_valid && s) begin
         m_wait = 0;
      end else if (m_valid) begin
         m_pc = m_nxt; m_nxt = m_nxt + 8'd1;
      end else if (m_wait > 1) begin
         m_wait = m_wait - 1;
      end else begin
         m_valid = 1'b1; m_zero = 1'b0; m_pc = m_nxt; m_nxt = m_nxt + 8'd1; m_wait = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input logic [AW-1:0] p);
      int n;
      n = 0;
      while (!(m_valid && m_pc == p) && n < 400) begin
         step(1'b0, 1'b0, 1'b0, 24'd0);
         n++;
      end
      if (!(m_valid && m_pc == p)) timeouts++;
   endtask

   task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Monitor: one queued expectation per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("valid_o", {31'd0, valid_o}, {31'd0, e.valid});
            check("rom_addr_o", {24'd0, rom_addr_o}, {24'd0, e.addr});
            if (e.valid) begin
               check("pc_o", {24'd0, pc_o}, {24'd0, e.pc});
               check("instr_o", instr_o, rom_word(e.pc));
               $display("deliver pc=%0d instr=%h stall=%0b br=%0b", pc_o, instr_o, stall_i, branch_taken_i);
            end else if (e.zero) begin
               check("pc_o_reset", {24'd0, pc_o}, 32'd0);
               check("instr_o_reset", instr_o, 32'd0);
            end
         end
      end
      check("run_until_bound", timeouts, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic r, s, b;
      logic [23:0] off;
      @(posedge clk);
      @(posedge clk);
      #1;
      // Reset for three cycles, then free-run with stall asserted over the start-up bubbles.
      step(1'b1, 1'b0, 1'b0, 24'd0);
      step(1'b1, 1'b1, 1'b0, 24'd0);
      step(1'b1, 1'b0, 1'b0, 24'd0);
      step(1'b0, 1'b1, 1'b0, 24'd0);
      step(1'b0, 1'b1, 1'b1, 24'd9);
      run_until(8'd5);
      repeat (3) step(1'b0, 1'b1, 1'b0, 24'd0);
      run_until(8'd10);
      step(1'b0, 1'b0, 1'b1, 24'd4);
      step(1'b0, 1'b0, 1'b1, 24'd7);
      run_until(8'd20);
      step(1'b0, 1'b1, 1'b1, 24'hFFFFED);
      run_until(8'd3);
      step(1'b0, 1'b0, 1'b1, 24'hFFFFFB);
      run_until(8'd0);
      step(1'b0, 1'b0, 1'b1, 24'd252);
      run_until(8'd1);
      step(1'b0, 1'b0, 1'b1, 24'd251);
      run_until(8'd254);
      step(1'b0, 1'b0, 1'b1, 24'd3);
      run_until(8'd3);
      // Reset arriving mid-stall and alongside a redirect.
      repeat (2) step(1'b0, 1'b1, 1'b0, 24'd0);
      repeat (2) step(1'b1, 1'b1, 1'b0, 24'd0);
      run_until(8'd4);
      step(1'b1, 1'b0, 1'b1, 24'd50);
      run_until(8'd2);
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(63) == 0);
         s   = ($urandom_range(3) == 0);
         b   = ($urandom_range(5) == 0);
         off = 24'($urandom);
         step(r, s, b, off);
      end
      done = 1'b1;
   end

endmodule
